aib_deskew_ctrl: RTL and testbench

AIB_DESKEW_CTRL -- requirements
Module: aib_deskew_ctrl

---
 rtl/aib_deskew_pkg.sv | 38 +++
 rtl/aib_deskew_grp_ramp.sv | 34 +++
 rtl/aib_deskew_ctrl.sv | 154 +++++++++++++++
 tb/tb_aib_deskew_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aib_deskew_pkg.sv
// Shared types and helpers for the AIB deskew controller: FSM state encoding,
// the default 102-lane / 4-group lane map and the saturating target multiply.
package aib_deskew_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RAMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_NUM_CH  = 102;
  localparam int DEF_NUM_GRP = 4;
  localparam int DEF_GRP_W   = 2;

  // Round-robin assignment: lane m belongs to group m mod 4.
  function automatic logic [DEF_NUM_CH*DEF_GRP_W-1:0] default_lane_grp();
    logic [DEF_NUM_CH*DEF_GRP_W-1:0] map;
    map = '0;
    for (int m = 0; m < DEF_NUM_CH; m++) begin
      map[m*DEF_GRP_W +: DEF_GRP_W] = DEF_GRP_W'(m % DEF_NUM_GRP);
    end
    return map;
  endfunction

  localparam logic [DEF_NUM_CH*DEF_GRP_W-1:0] DEFAULT_LANE_GRP = default_lane_grp();

  // Group index times step, clipped to the largest code; the product of a
  // group index and a code always fits in the 32-bit intermediate.
  function automatic int unsigned sat_mul(input int unsigned grp,
                                          input int unsigned step,
                                          input int unsigned lim);
    int unsigned prod;
    prod = grp * step;
    return (prod > lim) ? lim : prod;
  endfunction

endpackage

// File: rtl/aib_deskew_grp_ramp.sv
// One skew group's current code: either loads the target outright or walks
// toward it one LSB per step strobe, clamped at both ends of the code range.
module aib_deskew_grp_ramp
  import aib_deskew_pkg::*;
#(
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [CODE_W-1:0] tgt,
  output logic [CODE_W-1:0] cur
);

  logic [CODE_W-1:0] cur_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_p0 <= '0;
    end else if (load) begin
      cur_p0 <= tgt;
    end else if (step && (cur_p0 != tgt)) begin
      if ((cur_p0 < tgt) && (cur_p0 != '1)) begin
        cur_p0 <= cur_p0 + CODE_W'(1);
      end else if ((cur_p0 > tgt) && (cur_p0 != '0)) begin
        cur_p0 <= cur_p0 - CODE_W'(1);
      end
    end
  end

  assign cur = cur_p0;

endmodule

// File: rtl/aib_deskew_ctrl.sv
// AIB deskew controller: per-group skew targets, optional paced ramp and a
// registered per-lane output mux. Define AIB_DESKEW_RAMP_EN for paced ramping.
module aib_deskew_ctrl
  import aib_deskew_pkg::*;
#(
  parameter int NUM_CH   = 102,
  parameter int NUM_GRP  = 4,
  parameter int CODE_W   = 4,
  parameter int RAMP_DIV = 4,
  localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
  input  logic                    avmm_clk,
  input  logic                    avmm_rst_n,
  input  logic                    deskew_en,
  input  logic                    deskew_ovrd,
  input  logic [CODE_W-1:0]       deskew_step,
  input  logic [CODE_W-1:0]       deskew_data,
  input  logic [NUM_CH*GRP_W-1:0] lane_grp,
  input  logic                    deskew_upd,
  output logic [NUM_CH*CODE_W-1:0] deskew_out,
  output logic                    deskew_busy,
  output logic                    deskew_done
);

  localparam int unsigned      CODE_MAX = (1 << CODE_W) - 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GRP - 1);

  if ((RAMP_DIV < 1) || (RAMP_DIV > 255)) begin : g_div_range
    $error("aib_deskew_ctrl: RAMP_DIV must be within 1..255");
  end

  state_t              state, state_nxt;
  logic                en_q;
  logic [CODE_W-1:0]   step_q;
  logic [CODE_W-1:0]   tgt [NUM_GRP];
  logic [CODE_W-1:0]   cur [NUM_GRP];
  logic [GRP_W-1:0]    sel [NUM_CH];
  logic [NUM_CH*CODE_W-1:0] out_p1;
  logic                ramp_tick;
  logic                load_all;
  logic                ramp_done;

  // Stage 0: control state, latched request and per-group targets
  always_ff @(posedge avmm_clk) begin
    if (!avmm_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge avmm_clk) begin
    if (!avmm_rst_n) begin
      en_q   <= 1'b0;
      step_q <= '0;
    end else if (deskew_upd) begin
      en_q   <= deskew_en;
      step_q <= deskew_step;
    end
  end

  always_ff @(posedge avmm_clk) begin
    if (!avmm_rst_n) begin
      for (int g = 0; g < NUM_GRP; g++) tgt[g] <= '0;
    end else if (state == ST_LOAD) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        tgt[g] <= en_q ? CODE_W'(sat_mul(g, int'(step_q), CODE_MAX)) : '0;
      end
    end
  end

`ifdef AIB_DESKEW_RAMP_EN
  logic [7:0] div;
  logic       all_at;

  // The divider only runs in RAMP, so every re-entry through LOAD restarts it.
  always_ff @(posedge avmm_clk) begin
    if (!avmm_rst_n) begin
      div <= '0;
    end else if ((state != ST_RAMP) || ramp_tick) begin
      div <= '0;
    end else begin
      div <= div + 8'd1;
    end
  end

  always_comb begin
    all_at = 1'b1;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (cur[g] != tgt[g]) all_at = 1'b0;
    end
  end

  assign ramp_tick = (state == ST_RAMP) && (div == 8'(RAMP_DIV - 1));
  assign load_all  = 1'b0;
  assign ramp_done = all_at;
`else
  assign ramp_tick = 1'b0;
  assign load_all  = (state == ST_RAMP);
  assign ramp_done = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (deskew_upd) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_RAMP;
      ST_RAMP: if (ramp_done) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (deskew_upd) state_nxt = ST_LOAD;
  end

  always_comb begin
    deskew_busy = (state == ST_LOAD) || (state == ST_RAMP);
    deskew_done = (state == ST_DONE);
  end

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    aib_deskew_grp_ramp #(
      .CODE_W (CODE_W)
    ) u_ramp (
      .clk   (avmm_clk),
      .rst_n (avmm_rst_n),
      .load  (load_all),
      .step  (ramp_tick),
      .tgt   (tgt[g]),
      .cur   (cur[g])
    );
  end

  // Out-of-range group numbers fall back to the last group.
  always_comb begin
    for (int m = 0; m < NUM_CH; m++) begin
      sel[m] = lane_grp[m*GRP_W +: GRP_W];
      if (sel[m] > GRP_LAST) sel[m] = GRP_LAST;
    end
  end

  // Stage 1: registered lane codes
  always_ff @(posedge avmm_clk) begin
    if (!avmm_rst_n) begin
      out_p1 <= '0;
    end else begin
      for (int m = 0; m < NUM_CH; m++) begin
        out_p1[m*CODE_W +: CODE_W] <= deskew_ovrd ? deskew_data : cur[sel[m]];
      end
    end
  end

  assign deskew_out = out_p1;

endmodule

// File: tb/tb_aib_deskew_ctrl.sv
// Directed bench for aib_deskew_ctrl; expected timing follows AIB_DESKEW_RAMP_EN.
module tb_aib_deskew_ctrl;

  localparam int NUM_CH   = 102;
  localparam int NUM_GRP  = 4;
  localparam int GRP_W    = 2;
  localparam int CODE_W   = 4;
  localparam int RAMP_DIV = 4;
  localparam int BOUND    = 300;
`ifdef AIB_DESKEW_RAMP_EN
  localparam bit RAMP_MODE = 1'b1;
`else
  localparam bit RAMP_MODE = 1'b0;
`endif

  typedef struct packed {
    logic             en;
    logic [3:0]       step;
    logic [3:0][3:0]  tgt;
  } vec_t;

  logic                      avmm_clk = 1'b0;
  logic                      avmm_rst_n;
  logic                      deskew_en;
  logic                      deskew_ovrd;
  logic [CODE_W-1:0]         deskew_step;
  logic [CODE_W-1:0]         deskew_data;
  logic [NUM_CH*GRP_W-1:0]   lane_grp;
  logic                      deskew_upd;
  logic [NUM_CH*CODE_W-1:0]  deskew_out;
  logic                      deskew_busy;
  logic                      deskew_done;

  int checks   = 0;
  int failures = 0;

  aib_deskew_ctrl #(
    .NUM_CH   (NUM_CH),
    .NUM_GRP  (NUM_GRP),
    .CODE_W   (CODE_W),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .avmm_clk    (avmm_clk),
    .avmm_rst_n  (avmm_rst_n),
    .deskew_en   (deskew_en),
    .deskew_ovrd (deskew_ovrd),
    .deskew_step (deskew_step),
    .deskew_data (deskew_data),
    .lane_grp    (lane_grp),
    .deskew_upd  (deskew_upd),
    .deskew_out  (deskew_out),
    .deskew_busy (deskew_busy),
    .deskew_done (deskew_done)
  );

  always #5 avmm_clk = ~avmm_clk;

  function automatic int grp_of(int m);
    return (m / 2) % NUM_GRP;
  endfunction

  function automatic int absdiff(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Edges from the upd edge (counted as 1) to the edge that shows done.
  function automatic int exp_lat(int n);
    return RAMP_MODE ? 3 + n * RAMP_DIV : 3;
  endfunction

  task automatic tick();
    @(posedge avmm_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_lanes(input string name, input logic [3:0][3:0] exp);
    int bad;
    int act;
    bad = -1;
    act = 0;
    for (int m = 0; m < NUM_CH; m++) begin
      if (bad < 0 && deskew_out[m*CODE_W +: CODE_W] != exp[grp_of(m)]) begin
        bad = m;
        act = int'(deskew_out[m*CODE_W +: CODE_W]);
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: lane %0d got %0d expected %0d", name, bad, act,
               int'(exp[grp_of(bad)]));
    end
  endtask

  task automatic pulse_upd(input logic en, input logic [3:0] step);
    deskew_en   = en;
    deskew_step = step;
    deskew_upd  = 1'b1;
    tick();
    deskew_upd  = 1'b0;
  endtask

  task automatic wait_done(input int start, output int lat);
    int c;
    c   = start;
    lat = -1;
    while (c <= BOUND) begin
      if (deskew_done) begin
        lat = c;
        return;
      end
      tick();
      c++;
    end
  endtask

  task automatic count_done(input int cyc, output int pulses);
    pulses = 0;
    repeat (cyc) begin
      tick();
      if (deskew_done) pulses++;
    end
  endtask

  vec_t            vecs [7];
  logic [3:0][3:0] prev;
  logic [3:0][3:0] zero4;
  int              n, lat, pulses, pre;

  initial begin
    vecs[0] = '{en: 1'b1, step: 4'd1,  tgt: {4'd3,  4'd2,  4'd1,  4'd0}};
    vecs[1] = '{en: 1'b1, step: 4'd6,  tgt: {4'd15, 4'd12, 4'd6,  4'd0}};
    vecs[2] = '{en: 1'b0, step: 4'd6,  tgt: {4'd0,  4'd0,  4'd0,  4'd0}};
    vecs[3] = '{en: 1'b1, step: 4'd0,  tgt: {4'd0,  4'd0,  4'd0,  4'd0}};
    vecs[4] = '{en: 1'b1, step: 4'd15, tgt: {4'd15, 4'd15, 4'd15, 4'd0}};
    vecs[5] = '{en: 1'b1, step: 4'd5,  tgt: {4'd15, 4'd10, 4'd5,  4'd0}};
    vecs[6] = '{en: 1'b1, step: 4'd7,  tgt: {4'd15, 4'd14, 4'd7,  4'd0}};
    zero4 = '0;

    for (int m = 0; m < NUM_CH; m++) lane_grp[m*GRP_W +: GRP_W] = GRP_W'(grp_of(m));
    avmm_rst_n  = 1'b0;
    deskew_en   = 1'b0;
    deskew_ovrd = 1'b0;
    deskew_step = '0;
    deskew_data = '0;
    deskew_upd  = 1'b0;
    repeat (3) tick();
    check_lanes("reset_out", zero4);
    check("reset_busy", int'(deskew_busy), 0);
    check("reset_done", int'(deskew_done), 0);
    avmm_rst_n = 1'b1;
    tick();

    // Table: each update ramps from the previous targets (no restart from zero).
    prev = '0;
    for (int i = 0; i < 7; i++) begin
      n = 0;
      for (int g = 0; g < NUM_GRP; g++) begin
        if (absdiff(int'(vecs[i].tgt[g]), int'(prev[g])) > n)
          n = absdiff(int'(vecs[i].tgt[g]), int'(prev[g]));
      end
      pulse_upd(vecs[i].en, vecs[i].step);
      check($sformatf("v%0d_busy", i), int'(deskew_busy), 1);
      wait_done(1, lat);
      check($sformatf("v%0d_latency", i), lat, exp_lat(n));
      tick();
      check($sformatf("v%0d_done_pulse", i), int'(deskew_done), 0);
      check($sformatf("v%0d_idle_busy", i), int'(deskew_busy), 0);
      check_lanes($sformatf("v%0d_lanes", i), vecs[i].tgt);
      prev = vecs[i].tgt;
    end

    // Override during an update, then release: ramp timing unaffected.
    deskew_ovrd = 1'b1;
    deskew_data = 4'd9;
    pulse_upd(1'b1, 4'd2);
    check_lanes("ovrd_on", {4'd9, 4'd9, 4'd9, 4'd9});
    deskew_ovrd = 1'b0;
    tick();
    check_lanes("ovrd_off", prev);
    wait_done(2, lat);
    check("ovrd_latency", lat, exp_lat(10));
    tick();
    check_lanes("ovrd_final", {4'd6, 4'd4, 4'd2, 4'd0});

    // Reset in the middle of RAMP.
    pulse_upd(1'b1, 4'd3);
    tick();
    check("rst_pre_busy", int'(deskew_busy), 1);
    avmm_rst_n = 1'b0;
    tick();
    check_lanes("rst_mid_out", zero4);
    check("rst_mid_busy", int'(deskew_busy), 0);
    check("rst_mid_done", int'(deskew_done), 0);
    avmm_rst_n = 1'b1;
    count_done(20, pulses);
    check("rst_no_done", pulses, 0);
    check("rst_idle_busy", int'(deskew_busy), 0);

    // Re-update with en=0 while busy; cur is kept and ramps back down.
    pre = RAMP_MODE ? 6 : 1;
    pulse_upd(1'b1, 4'd1);
    for (int c = 1; c < pre; c++) tick();
    pulse_upd(1'b0, 4'd0);
    check_lanes("reupd_cur", RAMP_MODE ? {4'd1, 4'd1, 4'd1, 4'd0} : zero4);
    check("reupd_busy", int'(deskew_busy), 1);
    wait_done(1, lat);
    check("reupd_latency", lat, exp_lat(RAMP_MODE ? 1 : 0));
    count_done(10, pulses);
    check("reupd_single_done", pulses, 0);
    check_lanes("reupd_final", zero4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
